ppu_writeback: RTL and testbench
================================

Name: ppu_writeback

Overview:
Post-processing and write-back stage that sits directly downstream of the PE array's opsum port (GLB_opsum_valid/ready, GLB_data_out).
- Takes 32-bit signed psums in raster order, one output channel after another.
- Per element: requantize by arithmetic right shift with rounding, optional ReLU, saturate to int8.
- Optional 2x2/stride-2 max-pooling.
- Packs 4 int8 results per 32-bit word and writes them to the GLB at an opsum base address.

Parameters:
PSUM_BITS, 32, width of incoming partial sums
MAX_OW, 64, maximum ofmap width; sizes the pooling row buffer (MAX_OW/2 int8 entries)
ADDR_BITS, 32, GLB byte-address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; latches config and begins a job (ignored unless IDLE)
maxpool  in  1  enable 2x2 max-pool
relu  in  1  enable ReLU
scale  in  6  right-shift amount; values >31 treated as 31
ofmap_w  in  8  psum columns per row (1..MAX_OW)
ofmap_h  in  8  psum rows per channel (>=1)
num_ch  in  10  channels in job (>=1)
out_baseaddr  in  ADDR_BITS  word-aligned GLB byte address of first result
psum_valid  in  1  psum available
psum_ready  out  1  block accepts psum
psum_data  in  PSUM_BITS  signed psum
glb_we  out  4  per-byte write enables
glb_w_addr  out  ADDR_BITS  word-aligned byte address
glb_w_data  out  32  packed int8 results, byte 0 = earliest
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE; psum_ready=0, glb_we=0, glb_w_addr=0, glb_w_data=0, busy=0, done=0; all counters, pack buffer and row buffer valid bits cleared.
- FSM: IDLE -start-> RUN -last psum accepted and pipeline empty-> FLUSH -> DONE -> IDLE.
- FLUSH writes one word if 1-3 bytes are pending, otherwise it is a single idle cycle. DONE asserts done for one cycle and drops busy.
- Handshake: psum_ready=1 only in RUN and until the last psum (ofmap_w*ofmap_h*num_ch) is accepted. A transfer occurs when psum_valid&&psum_ready. GLB writes never stall.
- Quantize (stage 1, registered):
  - v = (sext33(psum) + (scale? 1<<(scale-1) : 0)) >>> scale.
  - If relu and v<0, v=0.
  - Saturate to [-128,127].
- Pooling (stage 2), with column counter x and row counter y per channel:
  - maxpool=0: every quantized value passes through.
  - maxpool=1, even x: hold the value. Odd x: hmax = max(held, value).
  - Even y: write hmax to rowbuf[x>>1]. Odd y: emit max(rowbuf[x>>1], hmax).
  - Odd trailing column or row is consumed but produces no output (floor semantics).
  - x, y and the channel counter wrap at ofmap_w, ofmap_h and num_ch.
- Packing (stage 3): results fill byte lanes 0..3.
  - On the 4th byte, the next cycle drives glb_we=4'b1111, glb_w_addr=out_baseaddr+4*word_idx and the packed data; word_idx then increments.
  - Packing is contiguous across channels, with no per-channel alignment.
  - Latency (maxpool=0): the completing psum accepted at cycle T gives its GLB write at T+3.
  - A partial final word is written in FLUSH with glb_we = lanes filled (e.g. 4'b0011); unused data bytes are 0.
- glb_we is 0 in every cycle without a write.
- start in a non-IDLE state is ignored. Config inputs are sampled only at start.
- rst_n low mid-job aborts immediately to reset values; pending bytes are discarded and no done pulse is issued.

Decomposition:
- Package ppu_pkg holds:
  - the state enum (IDLE, RUN, FLUSH, DONE)
  - the int8 min/max constants
  - a quantize function (round, shift, relu, saturate)
- Sub-module ppu_maxpool2x2 holds the row buffer, the hold register and the x/y/channel pooling logic.
- Top-level ppu_writeback holds the FSM, quantize register, packer and address generation.

Test Plan:
- scale=4, relu=0, maxpool=0, 4x1x1, base=0x100, psums {24,-24,2047,-3000} -> quantized {2,-1,127,-128} -> one write: addr 0x100, we=4'b1111, data 0x807FFF02.
- scale=0, relu=1, 3x1x1, psums {5,-7,300} -> {5,0,127} -> FLUSH write: we=4'b0111, data 0x007F0005, then done pulse.
- maxpool=1, scale=0, 4x4x1, psums 0..15 row-major -> pooled {5,7,13,15} -> single word 0x0F0D0705.
- maxpool=1, 5x3x1 (odd dims) -> 2 outputs only, the last row and last column ignored; 15 psums accepted; we=4'b0011 in FLUSH.
- Backpressure: psum_valid toggled randomly, 2x4x2 job -> results identical to the streaming run; psum_ready drops after psum 16; start during RUN ignored.
- Assert rst_n low mid-RUN -> all outputs at reset values in the same cycle; a new start after release runs a clean job from word_idx 0.

Source files
------------

// File: rtl/ppu_pkg.sv
// Shared types and arithmetic for the PPU write-back stage.
// Holds the FSM state type, int8 limits and the requantize/max helpers.
package ppu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic signed [7:0] INT8_MAX = 8'sh7F;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;

  // Round-half-up arithmetic shift, optional ReLU, then clamp to int8.
  // The 33-bit input leaves headroom for the rounding bias on a full-range psum.
  function automatic logic signed [7:0] quantize(input logic signed [32:0] ext,
                                                  input logic [4:0] shamt,
                                                  input logic relu_en);
    logic signed [32:0] bias;
    logic signed [32:0] v;
    bias = (shamt == 5'd0) ? 33'sd0 : (33'sd1 <<< (shamt - 5'd1));
    v = (ext + bias) >>> shamt;
    if (relu_en && (v < 33'sd0)) v = 33'sd0;
    if (v > 33'(INT8_MAX)) quantize = INT8_MAX;
    else if (v < 33'(INT8_MIN)) quantize = INT8_MIN;
    else quantize = v[7:0];
  endfunction

  function automatic logic signed [7:0] smax8(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
    smax8 = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ppu_maxpool2x2.sv
// 2x2 stride-2 max-pool over a raster stream of int8 values, one channel after another.
// Odd trailing columns/rows are consumed without producing output.
module ppu_maxpool2x2 #(
  parameter int MAX_OW = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              maxpool,
  input  logic [7:0]        ofmap_w,
  input  logic [7:0]        ofmap_h,
  input  logic [9:0]        num_ch,
  input  logic              in_valid,
  input  logic signed [7:0] in_data,
  output logic              out_valid,
  output logic signed [7:0] out_data
);
  import ppu_pkg::*;

  localparam int RB_DEPTH = MAX_OW / 2;
  localparam int IDX_W    = $clog2(RB_DEPTH);

  logic signed [7:0]   rowbuf [RB_DEPTH];
  logic [RB_DEPTH-1:0] rb_vld;
  logic [7:0]          x;
  logic [7:0]          y;
  logic [9:0]          ch;
  logic signed [7:0]   held;
  logic signed [7:0]   hmax;
  logic [IDX_W-1:0]    col;
  logic                last_x;
  logic                last_y;
  logic                last_ch;
  logic                rb_write;

  assign last_x   = (x == ofmap_w - 8'd1);
  assign last_y   = (y == ofmap_h - 8'd1);
  assign last_ch  = (ch == num_ch - 10'd1);
  assign col      = x[IDX_W:1];
  assign hmax     = smax8(held, in_data);
  assign rb_write = in_valid && maxpool && x[0] && !y[0];

  // Row buffer carries horizontal maxima from an even row to the following odd row.
  always_ff @(posedge clk) begin
    if (rb_write) rowbuf[col] <= hmax;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= 8'd0;
      y         <= 8'd0;
      ch        <= 10'd0;
      held      <= 8'sd0;
      rb_vld    <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'sd0;
    end else if (clear) begin
      x         <= 8'd0;
      y         <= 8'd0;
      ch        <= 10'd0;
      rb_vld    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        if (!maxpool) begin
          out_valid <= 1'b1;
          out_data  <= in_data;
        end else if (!x[0]) begin
          held <= in_data;
        end else if (!y[0]) begin
          rb_vld[col] <= 1'b1;
        end else if (rb_vld[col]) begin
          out_valid <= 1'b1;
          out_data  <= smax8(rowbuf[col], hmax);
        end

        if (last_x) begin
          x <= 8'd0;
          if (last_y) begin
            y      <= 8'd0;
            ch     <= last_ch ? 10'd0 : ch + 10'd1;
            rb_vld <= '0;
          end else begin
            y <= y + 8'd1;
          end
        end else begin
          x <= x + 8'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ppu_writeback.sv
// Post-processing write-back: requantize psums, optional 2x2 max-pool,
// pack four int8 results per word and write them to the GLB.
module ppu_writeback #(
  parameter int PSUM_BITS = 32,
  parameter int MAX_OW    = 64,
  parameter int ADDR_BITS = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 maxpool,
  input  logic                 relu,
  input  logic [5:0]           scale,
  input  logic [7:0]           ofmap_w,
  input  logic [7:0]           ofmap_h,
  input  logic [9:0]           num_ch,
  input  logic [ADDR_BITS-1:0] out_baseaddr,
  input  logic                 psum_valid,
  output logic                 psum_ready,
  input  logic [PSUM_BITS-1:0] psum_data,
  output logic [3:0]           glb_we,
  output logic [ADDR_BITS-1:0] glb_w_addr,
  output logic [31:0]          glb_w_data,
  output logic                 busy,
  output logic                 done
);
  import ppu_pkg::*;

  state_t                 state;
  state_t                 next_state;

  logic                   cfg_maxpool;
  logic                   cfg_relu;
  logic [4:0]             cfg_scale;
  logic [7:0]             cfg_w;
  logic [7:0]             cfg_h;
  logic [9:0]             cfg_ch;
  logic [ADDR_BITS-1:0]   cfg_base;
  logic [25:0]            total;
  logic [25:0]            acc_cnt;
  logic                   all_acc;

  logic                   start_job;
  logic                   accept;
  logic signed [32:0]     psum_ext;
  logic                   q_valid;
  logic signed [7:0]      q_data;
  logic                   p_valid;
  logic signed [7:0]      p_data;

  logic [23:0]            pack_buf;
  logic [1:0]             pack_cnt;
  logic [ADDR_BITS-3:0]   word_idx;
  logic [3:0]             flush_we;
  logic                   flush_now;

  assign start_job  = (state == IDLE) && start;
  assign psum_ready = (state == RUN) && !all_acc;
  assign accept     = psum_valid && psum_ready;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign psum_ext   = 33'(signed'(psum_data));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // The pipeline must drain before FLUSH so the partial word is final.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (all_acc && !q_valid && !p_valid) next_state = FLUSH;
      FLUSH:   next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_maxpool <= 1'b0;
      cfg_relu    <= 1'b0;
      cfg_scale   <= 5'd0;
      cfg_w       <= 8'd0;
      cfg_h       <= 8'd0;
      cfg_ch      <= 10'd0;
      cfg_base    <= '0;
      total       <= 26'd0;
    end else if (start_job) begin
      cfg_maxpool <= maxpool;
      cfg_relu    <= relu;
      cfg_scale   <= (scale > 6'd31) ? 5'd31 : scale[4:0];
      cfg_w       <= ofmap_w;
      cfg_h       <= ofmap_h;
      cfg_ch      <= num_ch;
      cfg_base    <= out_baseaddr;
      total       <= 26'(ofmap_w) * 26'(ofmap_h) * 26'(num_ch);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 26'd0;
      all_acc <= 1'b0;
      q_valid <= 1'b0;
      q_data  <= 8'sd0;
    end else begin
      q_valid <= accept;
      if (accept) q_data <= quantize(psum_ext, cfg_scale, cfg_relu);
      if (start_job) begin
        acc_cnt <= 26'd0;
        all_acc <= 1'b0;
      end else if (accept) begin
        acc_cnt <= acc_cnt + 26'd1;
        if (acc_cnt == total - 26'd1) all_acc <= 1'b1;
      end
    end
  end

  ppu_maxpool2x2 #(
    .MAX_OW(MAX_OW)
  ) u_pool (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_job),
    .maxpool  (cfg_maxpool),
    .ofmap_w  (cfg_w),
    .ofmap_h  (cfg_h),
    .num_ch   (cfg_ch),
    .in_valid (q_valid),
    .in_data  (q_data),
    .out_valid(p_valid),
    .out_data (p_data)
  );

  always_comb begin
    flush_we = 4'b0000;
    case (pack_cnt)
      2'd1:    flush_we = 4'b0001;
      2'd2:    flush_we = 4'b0011;
      2'd3:    flush_we = 4'b0111;
      default: flush_we = 4'b0000;
    endcase
  end

  assign flush_now = (state == RUN) && (next_state == FLUSH) && (pack_cnt != 2'd0);

  // Partial word is registered on the RUN->FLUSH edge so it appears during FLUSH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_buf   <= 24'd0;
      pack_cnt   <= 2'd0;
      word_idx   <= '0;
      glb_we     <= 4'b0000;
      glb_w_addr <= '0;
      glb_w_data <= 32'd0;
    end else begin
      glb_we <= 4'b0000;
      if (start_job) begin
        pack_buf <= 24'd0;
        pack_cnt <= 2'd0;
        word_idx <= '0;
      end else if (p_valid) begin
        if (pack_cnt == 2'd3) begin
          glb_we     <= 4'b1111;
          glb_w_addr <= cfg_base + {word_idx, 2'b00};
          glb_w_data <= {p_data, pack_buf};
          pack_buf   <= 24'd0;
          pack_cnt   <= 2'd0;
          word_idx   <= word_idx + 1'b1;
        end else begin
          case (pack_cnt)
            2'd0:    pack_buf[7:0]   <= p_data;
            2'd1:    pack_buf[15:8]  <= p_data;
            default: pack_buf[23:16] <= p_data;
          endcase
          pack_cnt <= pack_cnt + 2'd1;
        end
      end else if (flush_now) begin
        glb_we     <= flush_we;
        glb_w_addr <= cfg_base + {word_idx, 2'b00};
        glb_w_data <= {8'h00, pack_buf};
        pack_buf   <= 24'd0;
        pack_cnt   <= 2'd0;
        word_idx   <= word_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ppu_writeback.sv
// Scoreboard bench for ppu_writeback: a behavioural model queues the expected
// GLB writes per job, and a negedge monitor pops and compares them.
module tb_ppu_writeback;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        maxpool;
  logic        relu;
  logic [5:0]  scale;
  logic [7:0]  ofmap_w;
  logic [7:0]  ofmap_h;
  logic [9:0]  num_ch;
  logic [31:0] out_baseaddr;
  logic        psum_valid;
  logic        psum_ready;
  logic [31:0] psum_data;
  logic [3:0]  glb_we;
  logic [31:0] glb_w_addr;
  logic [31:0] glb_w_data;
  logic        busy;
  logic        done;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  int          stim[$];
  int          vectorCount = 0;
  int          missCount   = 0;
  int          cycleNum    = 0;
  int          doneCount   = 0;
  int          lastAccCycle   = 0;
  int          lastWriteCycle = 0;
  logic [31:0] lastWriteData  = 32'd0;
  logic [3:0]  lastWriteWe    = 4'd0;
  bit          ignoreWrites   = 1'b0;

  ppu_writeback dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .maxpool     (maxpool),
    .relu        (relu),
    .scale       (scale),
    .ofmap_w     (ofmap_w),
    .ofmap_h     (ofmap_h),
    .num_ch      (num_ch),
    .out_baseaddr(out_baseaddr),
    .psum_valid  (psum_valid),
    .psum_ready  (psum_ready),
    .psum_data   (psum_data),
    .glb_we      (glb_we),
    .glb_w_addr  (glb_w_addr),
    .glb_w_data  (glb_w_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleNum <= cycleNum + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Every GLB write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) doneCount++;
    if (rst_n && !ignoreWrites && glb_we != 4'b0000) begin
      lastWriteCycle = cycleNum;
      lastWriteData  = glb_w_data;
      lastWriteWe    = glb_we;
      if (expQ.size() == 0) begin
        checkOutput("extra_write_we", {28'd0, glb_we}, 32'd0);
      end else begin
        wr_t e;
        e = expQ.pop_front();
        checkOutput("wr_addr", glb_w_addr, e.addr);
        checkOutput("wr_we", {28'd0, glb_we}, {28'd0, e.we});
        checkOutput("wr_data", glb_w_data, e.data);
      end
    end
  end

  function automatic int modelQuant(input int p, input int sc, input bit rl);
    longint v;
    int     s;
    s = (sc > 31) ? 31 : sc;
    v = longint'(p);
    if (s > 0) v = v + (longint'(1) << (s - 1));
    v = v >>> s;
    if (rl && v < 0) v = 0;
    if (v > 127) v = 127;
    if (v < -128) v = -128;
    return int'(v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic buildExpected(input int w, input int h, input int ch, input int sc,
                               input bit rl, input bit mp, input logic [31:0] base);
    int  q[$];
    int  outs[$];
    int  lane;
    int  wordI;
    wr_t e;
    foreach (stim[i]) q.push_back(modelQuant(stim[i], sc, rl));
    if (!mp) begin
      outs = q;
    end else begin
      for (int c = 0; c < ch; c++)
        for (int py = 0; py < h / 2; py++)
          for (int px = 0; px < w / 2; px++) begin
            int b;
            b = c * w * h + 2 * py * w + 2 * px;
            outs.push_back(max2(max2(q[b], q[b + 1]), max2(q[b + w], q[b + w + 1])));
          end
    end
    lane = 0; wordI = 0; e.data = 32'd0; e.we = 4'd0; e.addr = 32'd0;
    foreach (outs[i]) begin
      e.data = e.data | ((32'(outs[i]) & 32'hFF) << (8 * lane));
      e.we[lane] = 1'b1;
      lane++;
      if (lane == 4) begin
        e.addr = base + 32'(4 * wordI);
        expQ.push_back(e);
        wordI++; lane = 0; e.data = 32'd0; e.we = 4'd0;
      end
    end
    if (lane != 0) begin
      e.addr = base + 32'(4 * wordI);
      expQ.push_back(e);
    end
  endtask

  // Starts a job, streams stim[] with optional random backpressure, waits for done.
  task automatic applyStimulus(input int w, input int h, input int ch, input int sc,
                               input bit rl, input bit mp, input logic [31:0] base,
                               input bit bp, input bit startInRun);
    int idx;
    int cyc;
    int d0;
    bit acc;
    buildExpected(w, h, ch, sc, rl, mp, base);
    d0 = doneCount;
    @(posedge clk); #1;
    ofmap_w = 8'(w); ofmap_h = 8'(h); num_ch = 10'(ch); scale = 6'(sc);
    relu = rl; maxpool = mp; out_baseaddr = base; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    ofmap_w = 8'd7; ofmap_h = 8'd9; num_ch = 10'd3; scale = 6'd1;
    relu = ~rl; maxpool = ~mp; out_baseaddr = 32'hDEAD0000;
    @(negedge clk);
    checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    idx = 0; cyc = 0;
    while (idx < stim.size() && cyc < 20 * stim.size() + 100) begin
      psum_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      psum_data  = stim[idx];
      start      = (startInRun && cyc == 3);
      @(negedge clk);
      acc = psum_valid && psum_ready;
      if (acc) lastAccCycle = cycleNum;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) idx++;
      cyc++;
    end
    psum_valid = 1'b0;
    if (idx < stim.size()) begin
      checkOutput("accept_timeout", 32'(idx), 32'(stim.size()));
    end else begin
      psum_valid = 1'b1;
      @(negedge clk);
      checkOutput("ready_after_last", {31'd0, psum_ready}, 32'd0);
      psum_valid = 1'b0;
    end
    cyc = 0;
    while (doneCount == d0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    checkOutput("done_pulses", 32'(doneCount - d0), 32'd1);
    checkOutput("busy_after_done", {31'd0, busy}, 32'd0);
    checkOutput("writes_left", 32'(expQ.size()), 32'd0);
    expQ.delete();
  endtask

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; maxpool = 1'b0; relu = 1'b0; scale = 6'd0;
    ofmap_w = 8'd1; ofmap_h = 8'd1; num_ch = 10'd1; out_baseaddr = 32'd0;
    psum_valid = 1'b0; psum_data = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", {31'd0, psum_ready}, 32'd0);
    checkOutput("rst_we", {28'd0, glb_we}, 32'd0);
    checkOutput("rst_addr", glb_w_addr, 32'd0);
    checkOutput("rst_data", glb_w_data, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    stim = '{24, -24, 2047, -3000};
    applyStimulus(4, 1, 1, 4, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0);
    checkOutput("job1_data", lastWriteData, 32'h807FFF02);
    checkOutput("job1_latency", 32'(lastWriteCycle - lastAccCycle), 32'd3);

    stim = '{5, -7, 300};
    applyStimulus(3, 1, 1, 0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0);
    checkOutput("job2_we", {28'd0, lastWriteWe}, 32'h7);
    checkOutput("job2_data", lastWriteData, 32'h007F0005);

    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(i);
    applyStimulus(4, 4, 1, 0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("job3_data", lastWriteData, 32'h0F0D0705);

    stim.delete();
    for (int i = 0; i < 15; i++) stim.push_back(i);
    applyStimulus(5, 3, 1, 0, 1'b0, 1'b1, 32'h80, 1'b0, 1'b0);
    checkOutput("job4_we", {28'd0, lastWriteWe}, 32'h3);
    checkOutput("job4_data", lastWriteData, 32'h00000806);

    stim.delete();
    for (int i = 0; i < 16; i++) stim.push_back(int'($urandom_range(0, 8000)) - 4000);
    applyStimulus(2, 4, 2, 5, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0);
    applyStimulus(2, 4, 2, 5, 1'b1, 1'b0, 32'h300, 1'b1, 1'b1);

    stim.delete();
    for (int i = 0; i < 72; i++) stim.push_back(int'($urandom_range(0, 4000)) - 2000);
    applyStimulus(6, 4, 3, 3, 1'b0, 1'b1, 32'h1000, 1'b1, 1'b0);

    stim = '{2147483647, -2147483647 - 1, 1073741824, -5};
    applyStimulus(2, 2, 1, 40, 1'b0, 1'b0, 32'h500, 1'b0, 1'b0);

    // Abort a job mid-stream, then run a clean one from the same base.
    ignoreWrites = 1'b1;
    @(posedge clk); #1;
    ofmap_w = 8'd4; ofmap_h = 8'd4; num_ch = 10'd1; scale = 6'd0;
    relu = 1'b0; maxpool = 1'b0; out_baseaddr = 32'h200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      psum_valid = 1'b1; psum_data = 32'(10 * i + 1);
      @(posedge clk); #1;
    end
    psum_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    d0 = doneCount;
    #1;
    checkOutput("abort_ready", {31'd0, psum_ready}, 32'd0);
    checkOutput("abort_we", {28'd0, glb_we}, 32'd0);
    checkOutput("abort_addr", glb_w_addr, 32'd0);
    checkOutput("abort_data", glb_w_data, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ignoreWrites = 1'b0;
    expQ.delete();
    repeat (3) @(posedge clk);
    checkOutput("abort_no_done", 32'(doneCount - d0), 32'd0);

    stim = '{16, 33, -48, 70, 5, -90, 1000, -1000};
    applyStimulus(4, 2, 1, 2, 1'b0, 1'b0, 32'h200, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
